// File: rtl/cacheline_burst_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory port: one line read becomes
// a 4-beat burst read reassembled into a line; one line write-back becomes a 4-beat burst write.
module cacheline_burst_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    // state | meaning
    // IDLE  | waiting for a line request; read has priority over write
    // RD    | collecting read beats from memory into the line buffer
    // WR    | presenting write beats from the line buffer to memory
    // DONE  | one-cycle line response to the cache
    localparam int NBEATS = LINE_W / BURST_W;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam logic [31:0] ALIGN_MASK = 32'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINE_W-1:0]  r_buf;
    logic [31:0]        r_addr;
    logic               w_last;
    logic [31:0]        w_aligned;
    logic [BURST_W-1:0] w_beat;

    assign w_last    = (r_cnt == CNT_W'(NBEATS - 1));
    assign w_aligned = address_i & ~ALIGN_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (read_i) begin
                    w_next = S_RD;
                end else if (write_i) begin
                    w_next = S_WR;
                end
            end
            S_RD:    if (resp_i && w_last) w_next = S_DONE;
            S_WR:    if (resp_i && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_buf  <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (read_i) begin
                        r_addr <= w_aligned;
                        r_cnt  <= '0;
                    end else if (write_i) begin
                        r_addr <= w_aligned;
                        r_buf  <= line_i;
                        r_cnt  <= '0;
                    end
                end
                S_RD: begin
                    if (resp_i) begin
                        for (int b = 0; b < NBEATS; b++) begin
                            if (r_cnt == CNT_W'(b)) begin
                                r_buf[b*BURST_W +: BURST_W] <= burst_i;
                            end
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat mux for the write path; beat 0 is the least-significant slice.
    always_comb begin
        w_beat = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                w_beat = r_buf[b*BURST_W +: BURST_W];
            end
        end
    end

    assign read_o    = (r_state == S_RD);
    assign write_o   = (r_state == S_WR);
    assign resp_o    = (r_state == S_DONE);
    assign address_o = r_addr;
    assign burst_o   = (r_state == S_WR) ? w_beat : '0;
    assign line_o    = r_buf;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: drivers push expected line responses and write beats into queues;
// a negedge monitor pops and compares whenever the adaptor presents a beat or a response.
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_burst_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rd;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] wbeat_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          last_rd = 1'b0;
    bit          prev_resp = 1'b0;

    task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (read_o) begin
                last_rd = 1'b1;
                if (exp_q.size() > 0) cmp("rd_addr", address_o, exp_q[0].addr);
            end
            if (write_o) begin
                last_rd = 1'b0;
                if (exp_q.size() > 0) cmp("wr_addr", address_o, exp_q[0].addr);
                if (resp_i) begin
                    if (wbeat_q.size() == 0) cmp("wr_beat_extra", 1, 0);
                    else cmp("wr_beat", burst_o, wbeat_q.pop_front());
                end
            end
            if (resp_o) begin
                exp_t e;
                cmp("resp_width", prev_resp, 0);
                if (exp_q.size() == 0) begin
                    cmp("resp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    cmp("resp_kind", last_rd, e.rd);
                    if (e.rd) cmp("line_o", line_o, e.line);
                end
            end
            prev_resp = resp_o;
        end else begin
            prev_resp = 1'b0;
        end
    end

    // Memory side: mode 0 = no gaps, 1 = random gaps, 2 = fixed strobe pattern (bit 0 first)
    task automatic serve(input bit rd, input logic [255:0] line, input int mode,
                         input logic [15:0] pat, output int lat, output int ncyc);
        int k;
        k    = 0;
        lat  = 0;
        ncyc = 0;
        while (!(rd ? read_o : write_o) && lat < 12) begin
            tick();
            lat++;
        end
        if (lat >= 12) begin
            cmp("busy_timeout", 0, 1);
            return;
        end
        while (k < 4 && ncyc < 64) begin
            bit go;
            cmp(rd ? "read_o_held" : "write_o_held", rd ? read_o : write_o, 1);
            cmp("resp_o_early", resp_o, 0);
            case (mode)
                0:       go = 1'b1;
                1:       go = ($urandom_range(0, 2) != 0);
                default: go = (ncyc < 16) ? pat[ncyc] : 1'b1;
            endcase
            ncyc++;
            resp_i  = go;
            burst_i = $urandom;
            if (go) begin
                if (rd) burst_i = line[k*64 +: 64];
                k++;
            end
            tick();
        end
        resp_i = 1'b0;
        cmp("resp_o_after_last", resp_o, 1);
        cmp("busy_drop", rd ? read_o : write_o, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int mode,
                           input logic [15:0] pat, output int lat, output int ncyc);
        exp_q.push_back('{1'b1, addr & ~32'h1F, line});
        address_i = addr;
        read_i    = 1'b1;
        serve(1'b1, line, mode, pat, lat, ncyc);
        read_i    = 1'b0;
        address_i = $urandom;
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int mode,
                            output int lat, output int ncyc);
        exp_q.push_back('{1'b0, addr & ~32'h1F, line});
        for (int b = 0; b < 4; b++) wbeat_q.push_back(line[b*64 +: 64]);
        address_i = addr;
        line_i    = line;
        write_i   = 1'b1;
        serve(1'b0, line, mode, 16'h0, lat, ncyc);
        write_i   = 1'b0;
        line_i    = rnd_line();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ncyc;
        logic [255:0] l1;
        logic [255:0] l2;
        logic [31:0]  a;

        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        repeat (3) tick();
        cmp("rst_read_o", read_o, 0);
        cmp("rst_write_o", write_o, 0);
        cmp("rst_resp_o", resp_o, 0);
        cmp("rst_address_o", address_o, 0);
        cmp("rst_burst_o", burst_o, 0);
        cmp("rst_line_o", line_o, 0);
        rst = 1'b1;
        tick();

        // Directed read, no gaps
        do_read(32'h0000_1234, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0, 16'h0, lat, ncyc);
        cmp("t1_req_latency", lat, 1);
        cmp("t1_beat_cycles", ncyc, 4);

        // Directed write, no gaps
        do_write(32'h8000_0040, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 0, lat, ncyc);
        cmp("t2_beat_cycles", ncyc, 4);

        // Read with strobe pattern 1,0,0,1,1,0,1
        do_read(32'h0000_5A5F, rnd_line(), 2, 16'h0059, lat, ncyc);
        cmp("t3_beat_cycles", ncyc, 7);

        // Reset after two read beats
        address_i = 32'h0000_0100;
        read_i    = 1'b1;
        tick();
        cmp("t4_read_o", read_o, 1);
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = $urandom;
            tick();
        end
        resp_i = 1'b0;
        rst    = 1'b0;
        #1;
        cmp("t4_rst_read_o", read_o, 0);
        cmp("t4_rst_resp_o", resp_o, 0);
        cmp("t4_rst_line_o", line_o, 0);
        cmp("t4_rst_address_o", address_o, 0);
        read_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        do_read(32'h0000_0100, rnd_line(), 1, 16'h0, lat, ncyc);

        // Simultaneous read and write: read first, write follows while held
        l1 = rnd_line();
        l2 = rnd_line();
        a  = 32'h1234_5678;
        exp_q.push_back('{1'b1, a & ~32'h1F, l1});
        exp_q.push_back('{1'b0, a & ~32'h1F, l2});
        for (int b = 0; b < 4; b++) wbeat_q.push_back(l2[b*64 +: 64]);
        address_i = a;
        line_i    = l2;
        read_i    = 1'b1;
        write_i   = 1'b1;
        serve(1'b1, l1, 1, 16'h0, lat, ncyc);
        read_i = 1'b0;
        serve(1'b0, l2, 1, 16'h0, lat, ncyc);
        cmp("t5_write_after_done", lat, 2);
        write_i = 1'b0;
        tick();

        // Back-to-back read then write
        do_read(32'hCAFE_0000, rnd_line(), 0, 16'h0, lat, ncyc);
        do_write(32'hCAFE_0020, rnd_line(), 0, lat, ncyc);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int op;
            op = $urandom_range(0, 2);
            a  = $urandom;
            if (op == 0) begin
                do_read(a, rnd_line(), 1, 16'h0, lat, ncyc);
            end else if (op == 1) begin
                do_write(a, rnd_line(), 1, lat, ncyc);
            end else begin
                l1 = rnd_line();
                l2 = rnd_line();
                exp_q.push_back('{1'b1, a & ~32'h1F, l1});
                exp_q.push_back('{1'b0, a & ~32'h1F, l2});
                for (int b = 0; b < 4; b++) wbeat_q.push_back(l2[b*64 +: 64]);
                address_i = a;
                line_i    = l2;
                read_i    = 1'b1;
                write_i   = 1'b1;
                serve(1'b1, l1, 1, 16'h0, lat, ncyc);
                read_i = 1'b0;
                serve(1'b0, l2, 1, 16'h0, lat, ncyc);
                write_i = 1'b0;
                tick();
            end
        end

        repeat (3) tick();
        cmp("exp_q_drained", exp_q.size(), 0);
        cmp("wbeat_q_drained", wbeat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
